// File: rtl/pdp8_trace_buffer.sv
// Instruction trace FIFO for the PDP-8 core: captures each issued instruction
// (opcode code, PC, effective address) on the rising edge of the exec-stage stall.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

package pdp8_trace_pkg;

    typedef struct packed {
        logic AND;
        logic TAD;
        logic ISZ;
        logic DCA;
        logic JMS;
        logic JMP;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;

    localparam int         NUM_FLAGS = 28;
    localparam logic [4:0] CODE_HLT  = 5'd18;
    localparam logic [4:0] CODE_NONE = 5'd31;

endpackage

module pdp8_trace_buffer
    import pdp8_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [`ADDR_WIDTH-1:0]        PC_value,
    input  logic [`ADDR_WIDTH-1:0]        base_addr,
    input  pdp_mem_opcode_s               pdp_mem_opcode,
    input  pdp_op7_opcode_s               pdp_op7_opcode,
    input  logic                          trace_pop,
    output logic                          trace_valid,
    output logic [4:0]                    trace_code,
    output logic [`ADDR_WIDTH-1:0]        trace_pc,
    output logic [`ADDR_WIDTH-1:0]        trace_addr,
    output logic [$clog2(DEPTH):0]        fifo_level,
    output logic [15:0]                   instr_count,
    output logic [7:0]                    drop_count,
    output logic                          halt_seen
);

    // Handshake: the head entry is valid while trace_valid=1; it is consumed at
    // the rising edge where trace_valid=1 and trace_pop=1. trace_pop while empty
    // is ignored. The producer side has no back-pressure: a capture into a full
    // FIFO is dropped and counted unless a pop frees the slot in the same cycle.

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE    = 1;
    localparam logic [PTR_W:0]    LEVEL_ONE  = 1;
    localparam logic [PTR_W:0]    LEVEL_FULL = (PTR_W + 1)'(DEPTH);

    logic                   stall_q;
    logic [NUM_FLAGS-1:0]   flags;
    logic [4:0]             issue_code;
    logic                   issue;
    logic                   valid_issue;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   do_push;
    logic                   do_pop;
    logic                   do_drop;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         level;

    logic [4:0]             code_mem [DEPTH];
    logic [`ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [`ADDR_WIDTH-1:0] addr_mem [DEPTH];

    // Flag vector indexed by trace code.
    always_comb begin
        flags     = '0;
        flags[0]  = pdp_mem_opcode.AND;
        flags[1]  = pdp_mem_opcode.TAD;
        flags[2]  = pdp_mem_opcode.ISZ;
        flags[3]  = pdp_mem_opcode.DCA;
        flags[4]  = pdp_mem_opcode.JMS;
        flags[5]  = pdp_mem_opcode.JMP;
        flags[6]  = pdp_op7_opcode.NOP;
        flags[7]  = pdp_op7_opcode.IAC;
        flags[8]  = pdp_op7_opcode.RAL;
        flags[9]  = pdp_op7_opcode.RTL;
        flags[10] = pdp_op7_opcode.RAR;
        flags[11] = pdp_op7_opcode.RTR;
        flags[12] = pdp_op7_opcode.CML;
        flags[13] = pdp_op7_opcode.CMA;
        flags[14] = pdp_op7_opcode.CIA;
        flags[15] = pdp_op7_opcode.CLL;
        flags[16] = pdp_op7_opcode.CLA1;
        flags[17] = pdp_op7_opcode.CLA_CLL;
        flags[18] = pdp_op7_opcode.HLT;
        flags[19] = pdp_op7_opcode.OSR;
        flags[20] = pdp_op7_opcode.SKP;
        flags[21] = pdp_op7_opcode.SNL;
        flags[22] = pdp_op7_opcode.SZL;
        flags[23] = pdp_op7_opcode.SZA;
        flags[24] = pdp_op7_opcode.SNA;
        flags[25] = pdp_op7_opcode.SMA;
        flags[26] = pdp_op7_opcode.SPA;
        flags[27] = pdp_op7_opcode.CLA2;
    end

    // Scanning from the top down lets the lowest set flag win.
    always_comb begin
        issue_code = CODE_NONE;
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (flags[i]) begin
                issue_code = 5'(i);
            end
        end
    end

    assign issue       = stall && !stall_q;
    assign valid_issue = issue && (issue_code != CODE_NONE);
    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == LEVEL_FULL);
    assign do_pop      = trace_pop && !fifo_empty;
    assign do_push     = valid_issue && (!fifo_full || do_pop);
    assign do_drop     = valid_issue && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            instr_count <= '0;
            drop_count  <= '0;
            halt_seen   <= 1'b0;
        end else begin
            stall_q <= stall;

            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({do_push, do_pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase

            if (valid_issue && (instr_count != 16'hFFFF)) begin
                instr_count <= instr_count + 16'd1;
            end
            if (do_drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            // A dropped HLT still marks the halt as seen.
            if (valid_issue && (issue_code == CODE_HLT)) begin
                halt_seen <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            code_mem[wr_ptr] <= issue_code;
            pc_mem[wr_ptr]   <= PC_value;
            addr_mem[wr_ptr] <= base_addr;
        end
    end

    assign fifo_level  = level;
    assign trace_valid = !fifo_empty;
    assign trace_code  = fifo_empty ? '0 : code_mem[rd_ptr];
    assign trace_pc    = fifo_empty ? '0 : pc_mem[rd_ptr];
    assign trace_addr  = fifo_empty ? '0 : addr_mem[rd_ptr];

endmodule

// File: tb/tb_pdp8_trace_buffer.sv
// Directed bench for pdp8_trace_buffer: capture, ordering, overflow, saturation
// and reset behaviour, with expected entries tracked in a queue.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

module tb_pdp8_trace_buffer;
    import pdp8_trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = `ADDR_WIDTH;
    localparam int EW    = 5 + 2 * AW;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   stall;
    logic                   trace_pop;
    logic [AW-1:0]          pc_value;
    logic [AW-1:0]          base_addr;
    logic [27:0]            flag_vec;
    pdp_mem_opcode_s        mem_op;
    pdp_op7_opcode_s        op7;
    logic                   trace_valid;
    logic [4:0]             trace_code;
    logic [AW-1:0]          trace_pc;
    logic [AW-1:0]          trace_addr;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0]            instr_count;
    logic [7:0]             drop_count;
    logic                   halt_seen;

    logic [EW-1:0]          exp_q[$];
    int                     tests = 0;
    int                     fails = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always_comb begin
        mem_op         = '0;
        op7            = '0;
        mem_op.AND     = flag_vec[0];
        mem_op.TAD     = flag_vec[1];
        mem_op.ISZ     = flag_vec[2];
        mem_op.DCA     = flag_vec[3];
        mem_op.JMS     = flag_vec[4];
        mem_op.JMP     = flag_vec[5];
        op7.NOP        = flag_vec[6];
        op7.IAC        = flag_vec[7];
        op7.RAL        = flag_vec[8];
        op7.RTL        = flag_vec[9];
        op7.RAR        = flag_vec[10];
        op7.RTR        = flag_vec[11];
        op7.CML        = flag_vec[12];
        op7.CMA        = flag_vec[13];
        op7.CIA        = flag_vec[14];
        op7.CLL        = flag_vec[15];
        op7.CLA1       = flag_vec[16];
        op7.CLA_CLL    = flag_vec[17];
        op7.HLT        = flag_vec[18];
        op7.OSR        = flag_vec[19];
        op7.SKP        = flag_vec[20];
        op7.SNL        = flag_vec[21];
        op7.SZL        = flag_vec[22];
        op7.SZA        = flag_vec[23];
        op7.SNA        = flag_vec[24];
        op7.SMA        = flag_vec[25];
        op7.SPA        = flag_vec[26];
        op7.CLA2       = flag_vec[27];
    end

    pdp8_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .PC_value       (pc_value),
        .base_addr      (base_addr),
        .pdp_mem_opcode (mem_op),
        .pdp_op7_opcode (op7),
        .trace_pop      (trace_pop),
        .trace_valid    (trace_valid),
        .trace_code     (trace_code),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .fifo_level     (fifo_level),
        .instr_count    (instr_count),
        .drop_count     (drop_count),
        .halt_seen      (halt_seen)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle (stall low) then one stall-high cycle carrying the given flags.
    task automatic issue_raw(input logic [27:0] vec, input int pc, input int addr,
                             input bit pop);
        stall = 1'b0;
        trace_pop = 1'b0;
        flag_vec = '0;
        tick();
        stall = 1'b1;
        flag_vec = vec;
        pc_value = AW'(pc);
        base_addr = AW'(addr);
        trace_pop = pop;
        tick();
        stall = 1'b0;
        trace_pop = 1'b0;
        flag_vec = '0;
    endtask

    // keep=1: the entry is expected to land in the FIFO.
    task automatic issue(input int code, input int pc, input int addr, input bit pop,
                         input bit keep);
        logic [27:0] vec;
        vec = (code == 31) ? 28'd0 : (28'd1 << code);
        if (pop) void'(exp_q.pop_front());
        if (keep) exp_q.push_back({5'(code), AW'(pc), AW'(addr)});
        issue_raw(vec, pc, addr, pop);
    endtask

    task automatic drain(input string tag);
        logic [EW-1:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ".valid"}, 32'(trace_valid), 32'd1);
            check({tag, ".code"}, 32'(trace_code), 32'(e[EW-1 -: 5]));
            check({tag, ".pc"}, 32'(trace_pc), 32'(e[2*AW-1 -: AW]));
            check({tag, ".addr"}, 32'(trace_addr), 32'(e[AW-1:0]));
            trace_pop = 1'b1;
            tick();
            trace_pop = 1'b0;
        end
        check({tag, ".empty"}, 32'(trace_valid), 32'd0);
        check({tag, ".level0"}, 32'(fifo_level), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(trace_valid), 32'd0);
        check({tag, ".code"}, 32'(trace_code), 32'd0);
        check({tag, ".pc"}, 32'(trace_pc), 32'd0);
        check({tag, ".addr"}, 32'(trace_addr), 32'd0);
        check({tag, ".level"}, 32'(fifo_level), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        trace_pop = 1'b0;
        flag_vec = '0;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset with an issue pending: it is lost, then counts right after reset.
        reset = 1'b1;
        stall = 1'b1;
        trace_pop = 1'b0;
        flag_vec = 28'd1 << 17;
        pc_value = AW'('o200);
        base_addr = AW'('o045);
        tick();
        tick();
        check_idle("rst");
        check("rst.instr", 32'(instr_count), 32'd0);
        check("rst.drop", 32'(drop_count), 32'd0);
        check("rst.halt", 32'(halt_seen), 32'd0);

        reset = 1'b0;
        tick();
        check("first.valid", 32'(trace_valid), 32'd1);
        check("first.code", 32'(trace_code), 32'd17);
        check("first.pc", 32'(trace_pc), 32'o200);
        check("first.level", 32'(fifo_level), 32'd1);
        check("first.instr", 32'(instr_count), 32'd1);
        stall = 1'b0;
        flag_vec = '0;
        exp_q.push_back({5'd17, AW'('o200), AW'('o045)});

        // Program order CLA_CLL, TAD, TAD, DCA, HLT, JMP.
        issue(1, 'o201, 'o401, 0, 1);
        issue(1, 'o202, 'o402, 0, 1);
        issue(3, 'o203, 'o403, 0, 1);
        check("seq.halt_before", 32'(halt_seen), 32'd0);
        issue(18, 'o204, 'o000, 0, 1);
        check("seq.halt_after", 32'(halt_seen), 32'd1);
        issue(5, 'o205, 'o210, 0, 1);
        check("seq.level", 32'(fifo_level), 32'd6);
        check("seq.instr", 32'(instr_count), 32'd6);
        check("seq.drop", 32'(drop_count), 32'd0);
        drain("seq");

        // Pop while empty changes nothing.
        trace_pop = 1'b1;
        tick();
        trace_pop = 1'b0;
        check_idle("pop_empty");
        check("pop_empty.instr", 32'(instr_count), 32'd6);

        // Stall held high for five cycles is one issue.
        flag_vec = 28'd1;
        pc_value = AW'('o300);
        base_addr = AW'('o1234);
        stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0;
        flag_vec = '0;
        exp_q.push_back({5'd0, AW'('o300), AW'('o1234)});
        check("hold.level", 32'(fifo_level), 32'd1);
        check("hold.instr", 32'(instr_count), 32'd7);

        // No opcode flags: ignored.
        issue(31, 'o301, 'o1, 0, 0);
        check("noop.level", 32'(fifo_level), 32'd1);
        check("noop.instr", 32'(instr_count), 32'd7);

        // TAD + HLT + CLA2 together: lowest code (TAD) wins.
        issue_raw((28'd1 << 1) | (28'd1 << 18) | (28'd1 << 27), 'o310, 'o311, 0);
        exp_q.push_back({5'd1, AW'('o310), AW'('o311)});
        check("prio.level", 32'(fifo_level), 32'd2);
        check("prio.instr", 32'(instr_count), 32'd8);
        drain("prio");

        // Overflow: ten pushes into eight slots.
        do_reset();
        check("ovf.halt_clr", 32'(halt_seen), 32'd0);
        for (int i = 0; i < 10; i++) begin
            issue(i, 'o300 + i, 'o1000 + 3 * i, 0, i < 8);
        end
        check("ovf.level", 32'(fifo_level), 32'd8);
        check("ovf.drop", 32'(drop_count), 32'd2);
        check("ovf.instr", 32'(instr_count), 32'd10);
        check("ovf.head", 32'(trace_code), 32'd0);

        // Pop coinciding with an issue while full.
        issue(20, 'o777, 'o7, 1, 1);
        check("fullpop.level", 32'(fifo_level), 32'd8);
        check("fullpop.drop", 32'(drop_count), 32'd2);
        check("fullpop.instr", 32'(instr_count), 32'd11);
        check("fullpop.head", 32'(trace_code), 32'd1);
        check("fullpop.halt", 32'(halt_seen), 32'd0);
        drain("fullpop");

        // Reset mid-stream discards everything.
        do_reset();
        issue(2, 'o400, 'o10, 0, 1);
        issue(18, 'o401, 'o11, 0, 1);
        issue(4, 'o402, 'o12, 0, 1);
        issue(6, 'o403, 'o13, 0, 1);
        issue(7, 'o404, 'o14, 0, 1);
        check("mid.level", 32'(fifo_level), 32'd5);
        check("mid.halt", 32'(halt_seen), 32'd1);
        do_reset();
        check_idle("mid_rst");
        check("mid_rst.instr", 32'(instr_count), 32'd0);
        check("mid_rst.halt", 32'(halt_seen), 32'd0);
        trace_pop = 1'b1;
        tick();
        trace_pop = 1'b0;
        check_idle("mid_rst_pop");

        // drop_count saturation; a dropped HLT still sets halt_seen.
        for (int i = 0; i < 8; i++) begin
            issue(6 + i, 'o500 + i, 'o20 + i, 0, 1);
        end
        for (int i = 0; i < 259; i++) begin
            issue(0, 'o600, 'o0, 0, 0);
        end
        check("sat.halt_before", 32'(halt_seen), 32'd0);
        issue(18, 'o601, 'o0, 0, 0);
        check("sat.drop", 32'(drop_count), 32'd255);
        check("sat.instr", 32'(instr_count), 32'd268);
        check("sat.level", 32'(fifo_level), 32'd8);
        check("sat.halt", 32'(halt_seen), 32'd1);
        drain("sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
